// File: rtl/seq_det_arb.sv
// Shared serial pattern detector arbitrated between two requesters.
// The owner streams up to FRAME valid bits; the block reports matches and frame completion or abort.
module seq_det_arb #(
    parameter logic [7:0] PAT   = 8'b0000_1001,
    parameter int         PLEN  = 4,
    parameter int         FRAME = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] bit_in,
    input  logic [1:0] bit_vld,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       match,
    output logic       frame_done,
    output logic       aborted,
    output logic       done_id,
    output logic [7:0] match_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [7:0] MASK      = 8'((9'd1 << PLEN) - 9'd1);
    localparam logic [7:0] FRAME_LEN = 8'(FRAME);
    localparam logic [7:0] PAT_LEN   = 8'(PLEN);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_owner;
    logic       r_last;
    logic       r_served;
    logic       r_aborted;
    logic       r_done_id;
    logic       r_match;
    logic [7:0] r_hist;
    logic [7:0] r_bit_cnt;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_match_cnt;

    logic       w_pick;
    logic       w_owner_req;
    logic       w_owner_vld;
    logic       w_owner_bit;
    logic       w_consume;
    logic       w_hit;
    logic [7:0] w_hist_next;
    logic [7:0] w_bit_cnt_next;
    logic [7:0] w_frame_cnt_next;

    // Tie goes to whoever was not served last; before any frame has finished, requester 0 wins.
    always_comb begin
        w_pick = 1'b0;
        if (req == 2'b11)
            w_pick = r_served ? ~r_last : 1'b0;
        else if (req[1])
            w_pick = 1'b1;
    end

    assign w_owner_req    = req[r_owner];
    assign w_owner_vld    = bit_vld[r_owner];
    assign w_owner_bit    = bit_in[r_owner];
    assign w_consume      = (r_state == S_RUN) && w_owner_req && w_owner_vld;
    assign w_hist_next    = (r_hist << 1) | {7'd0, w_owner_bit};
    assign w_bit_cnt_next = r_bit_cnt + 8'd1;
    assign w_hit          = ((w_hist_next & MASK) == (PAT & MASK)) && (w_bit_cnt_next >= PAT_LEN);

    always_comb begin
        w_frame_cnt_next = r_frame_cnt;
        if (w_consume && w_hit && (r_frame_cnt != 8'hFF))
            w_frame_cnt_next = r_frame_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (|req)
                    w_state_next = S_RUN;
            end
            S_RUN: begin
                // Dropping req wins over a bit presented in the same cycle.
                if (!w_owner_req)
                    w_state_next = S_DONE;
                else if (w_owner_vld && (w_bit_cnt_next == FRAME_LEN))
                    w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= 1'b0;
            r_last      <= 1'b0;
            r_served    <= 1'b0;
            r_aborted   <= 1'b0;
            r_done_id   <= 1'b0;
            r_match     <= 1'b0;
            r_hist      <= 8'd0;
            r_bit_cnt   <= 8'd0;
            r_frame_cnt <= 8'd0;
            r_match_cnt <= 8'd0;
        end else begin
            r_match <= w_consume && w_hit;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_owner     <= w_pick;
                        r_hist      <= 8'd0;
                        r_bit_cnt   <= 8'd0;
                        r_frame_cnt <= 8'd0;
                    end
                end
                S_RUN: begin
                    if (w_consume) begin
                        r_hist      <= w_hist_next;
                        r_bit_cnt   <= w_bit_cnt_next;
                        r_frame_cnt <= w_frame_cnt_next;
                    end
                    if (w_state_next == S_DONE) begin
                        r_match_cnt <= w_frame_cnt_next;
                        r_aborted   <= ~w_owner_req;
                        r_done_id   <= r_owner;
                    end
                end
                S_DONE: begin
                    r_last   <= r_owner;
                    r_served <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state == S_RUN);
    assign frame_done = (r_state == S_DONE);
    assign aborted    = frame_done & r_aborted;
    assign done_id    = r_done_id;
    assign match      = r_match;
    assign match_cnt  = r_match_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt[gi] = busy && (r_owner == 1'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_seq_det_arb.sv
// Directed bench for seq_det_arb: expected grants and frame results are queued at stimulus time
// and popped by a monitor when the design starts a frame or reports frame_done.
module tb_seq_det_arb;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] bit_in;
    logic [1:0] bit_vld;
    logic [1:0] gnt;
    logic       busy;
    logic       match;
    logic       frame_done;
    logic       aborted;
    logic       done_id;
    logic [7:0] match_cnt;

    seq_det_arb dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .bit_in     (bit_in),
        .bit_vld    (bit_vld),
        .gnt        (gnt),
        .busy       (busy),
        .match      (match),
        .frame_done (frame_done),
        .aborted    (aborted),
        .done_id    (done_id),
        .match_cnt  (match_cnt)
    );

    typedef struct {
        int id;
        int ab;
        int cnt;
    } frm_t;

    logic [1:0] exp_gnt_q[$];
    frm_t       exp_frm_q[$];

    int checks = 0;
    int passes = 0;
    int pulses = 0;
    bit prev_busy = 0;
    bit gnt11_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Independent reference: count overlapping 1001 windows in an MSB-first stream.
    function automatic int count_matches(input logic [31:0] bits, input int n);
        int c = 0;
        for (int k = 3; k < n; k++) begin
            if (bits[n-1-(k-3)] == 1'b1 && bits[n-1-(k-2)] == 1'b0 &&
                bits[n-1-(k-1)] == 1'b0 && bits[n-1-k] == 1'b1)
                c++;
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            pulses    = 0;
            prev_busy = 0;
        end else begin
            if (gnt == 2'b11) gnt11_seen = 1;
            if (match) pulses++;
            if (busy && !prev_busy) begin
                check("gnt_queue_has_entry", 32'(exp_gnt_q.size() != 0), 32'd1);
                if (exp_gnt_q.size() != 0) begin
                    logic [1:0] eg;
                    eg = exp_gnt_q.pop_front();
                    check("gnt_at_frame_start", 32'(gnt), 32'(eg));
                end
            end
            if (frame_done) begin
                check("frame_queue_has_entry", 32'(exp_frm_q.size() != 0), 32'd1);
                if (exp_frm_q.size() != 0) begin
                    frm_t ef;
                    ef = exp_frm_q.pop_front();
                    check("done_id", 32'(done_id), 32'(ef.id));
                    check("aborted", 32'(aborted), 32'(ef.ab));
                    check("match_cnt", 32'(match_cnt), 32'(ef.cnt));
                    check("match_pulses", 32'(pulses), 32'(ef.cnt));
                    $display("frame: id=%0d aborted=%0d match_cnt=%0d pulses=%0d", done_id, aborted, match_cnt, pulses);
                end
                pulses = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic do_reset();
        rst = 1'b1; req = 2'b00; bit_in = 2'b00; bit_vld = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        check("rst_match_cnt", 32'(match_cnt), 32'd0);
        rst = 1'b0;
    endtask

    // One frame for requester id; abort_after drops req after n bits with a bit still presented.
    task automatic run_frame(input int id, input logic [31:0] bits, input int n,
                             input bit sparse, input bit abort_after);
        int   other = 1 - id;
        bit   got = 0;
        int   exp_cnt;
        logic last_hit;
        exp_cnt  = count_matches(bits, n);
        last_hit = (n >= 4) && (bits[3:0] == 4'b1001);
        exp_gnt_q.push_back(id == 1 ? 2'b10 : 2'b01);
        exp_frm_q.push_back('{id: id, ab: int'(abort_after), cnt: exp_cnt});
        req[id] = 1'b1;
        for (int w = 0; w < 20 && !got; w++) begin
            @(posedge clk); #1;
            if (gnt[id]) got = 1;
        end
        check("grant_within_budget", 32'(got), 32'd1);
        if (!got) begin
            req[id] = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            bit_vld[id]    = 1'b1;
            bit_in[id]     = bits[n-1-i];
            bit_vld[other] = 1'b1;
            bit_in[other]  = 1'($urandom);
            if (i == n - 1) check("busy_before_last_bit", 32'(busy), 32'd1);
            @(posedge clk); #1;
            if (sparse && i != n - 1) begin
                bit_vld[id] = 1'b0;
                @(posedge clk); #1;
            end
        end
        if (abort_after) begin
            req[id] = 1'b0; bit_vld[id] = 1'b1; bit_in[id] = 1'b1;
            @(posedge clk); #1;
            check("abort_frame_done", 32'(frame_done), 32'd1);
            check("abort_flag", 32'(aborted), 32'd1);
        end else begin
            check("frame_done_on_last_bit", 32'(frame_done), 32'd1);
            check("match_on_last_bit", 32'(match), 32'(last_hit));
            check("complete_not_aborted", 32'(aborted), 32'd0);
        end
        req = 2'b00; bit_vld = 2'b00; bit_in = 2'b00;
        @(posedge clk); #1;
    endtask

    initial begin
        int done_seen;
        bit got;
        do_reset();

        run_frame(0, 32'b1001001000000000, 16, 1'b0, 1'b0);
        run_frame(1, 32'b10010, 5, 1'b0, 1'b1);
        run_frame(0, 32'b100, 3, 1'b0, 1'b1);
        run_frame(0, 32'hA5C9, 16, 1'b1, 1'b0);
        run_frame(1, 32'h9249, 16, 1'b0, 1'b0);

        // Both requesters held from reset: alternation 01, 10, 01.
        do_reset();
        exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b10); exp_gnt_q.push_back(2'b01);
        exp_frm_q.push_back('{id: 0, ab: 0, cnt: 0});
        exp_frm_q.push_back('{id: 1, ab: 0, cnt: 0});
        exp_frm_q.push_back('{id: 0, ab: 0, cnt: 0});
        req = 2'b11; bit_vld = 2'b11; bit_in = 2'b00;
        done_seen = 0;
        for (int c = 0; c < 200 && done_seen < 3; c++) begin
            @(posedge clk); #1;
            if (frame_done) done_seen++;
        end
        req = 2'b00; bit_vld = 2'b00;
        check("three_tie_frames", 32'(done_seen), 32'd3);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-frame: frame owned by 1 is dropped silently, next tie restarts at 0.
        exp_gnt_q.push_back(2'b10);
        req = 2'b11; bit_vld = 2'b11; bit_in = 2'b00;
        got = 0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(posedge clk); #1;
            if (busy) got = 1;
        end
        check("busy_before_reset", 32'(got), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrun_rst_gnt", 32'(gnt), 32'd0);
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_frame_done", 32'(frame_done), 32'd0);
        check("midrun_rst_match_cnt", 32'(match_cnt), 32'd0);
        exp_gnt_q.push_back(2'b01);
        exp_frm_q.push_back('{id: 0, ab: 1, cnt: 0});
        rst = 1'b0;
        got = 0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(posedge clk); #1;
            if (busy) got = 1;
        end
        check("post_reset_tie_gnt", 32'(gnt), 32'd1);
        req = 2'b00; bit_vld = 2'b00;
        @(posedge clk); #1;
        check("post_reset_abort_done", 32'(frame_done), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        check("gnt_never_11", 32'(gnt11_seen), 32'd0);
        check("gnt_queue_drained", 32'(exp_gnt_q.size()), 32'd0);
        check("frame_queue_drained", 32'(exp_frm_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_det_arb.md
SEQ_DET_ARB -- requirements
Module: seq_det_arb

Interface
REQ-001 Parameter PAT, default 4'b1001: pattern to detect, MSB is the first bit received.
REQ-002 Parameter PLEN, default 4: pattern length in bits; legal range 1..8.
REQ-003 Parameter FRAME, default 16: valid bits per granted frame; legal range PLEN..255.
REQ-004 clk  in  1  clock; every register updates on the rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 req  in  2  per-requester request for the shared detector; held high for the whole frame.
REQ-007 bit_in  in  2  per-requester serial data bit.
REQ-008 bit_vld  in  2  per-requester qualifier for bit_in.
REQ-009 gnt  out  2  one-hot grant; all zero when idle.
REQ-010 busy  out  1  high while a frame is owned.
REQ-011 match  out  1  single-cycle pulse on pattern detection.
REQ-012 frame_done  out  1  single-cycle pulse when a frame completes or aborts.
REQ-013 aborted  out  1  valid with frame_done; 1 means the owner dropped req early.
REQ-014 done_id  out  1  index of the requester that owned the finished frame.
REQ-015 match_cnt  out  8  match count of the last finished frame; held until the next frame_done.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN and DONE, all registered.
REQ-017 IDLE: with any req high, the block SHALL latch the owner by round-robin, assert gnt[owner] and busy, and enter RUN on the next edge.
REQ-018 Round-robin: with both req high, the requester not served last SHALL win; after reset, requester 0 SHALL win a tie.
REQ-019 RUN: only bit_in[owner] gated by bit_vld[owner] SHALL be sampled; the other requester's inputs SHALL be ignored.
REQ-020 Each valid bit SHALL shift into an 8-bit history register, newest bit at the LSB, and increment a bit counter.
REQ-021 match SHALL pulse in the cycle after a valid bit when both hold:
- the low PLEN history bits equal PAT;
- at least PLEN bits have been received in this frame.
REQ-022 Overlapping matches SHALL count, with no history clear after a match; stream 1001001 gives 2 matches.
REQ-023 The frame match counter SHALL increment per match and saturate at 255.
REQ-024 When the FRAME-th valid bit is consumed, the FSM SHALL enter DONE; a match on that bit SHALL still count and pulse.
REQ-025 DONE: for one cycle, frame_done=1, aborted=0, done_id=owner, match_cnt=frame counter; gnt and busy SHALL be 0; then IDLE.
REQ-026 req[owner] low during RUN SHALL abort:
- next cycle is DONE with aborted=1;
- match_cnt is loaded with the partial count;
- a bit valid in the abort cycle is discarded.
REQ-027 The round-robin pointer SHALL update to the owner on every DONE, whether the frame completed or aborted.
REQ-028 History register, bit counter and frame counter SHALL clear on entry to RUN; frames SHALL NOT share history.
REQ-029 A requester still holding req after DONE SHALL be treated as a new request in IDLE; minimum gap between frames is 2 cycles.
REQ-030 gnt SHALL never have more than one bit set.

Reset
REQ-031 rst high SHALL force at the next edge:
- state IDLE;
- gnt=0, busy=0, match=0, frame_done=0, aborted=0, done_id=0, match_cnt=0;
- history, counters and pointer cleared.
REQ-032 rst asserted mid-frame SHALL drop the frame with no frame_done pulse.

Verification
REQ-033 Defaults, req=01, stream 1001001 then 0s to 16 bits -> two match pulses; frame_done with match_cnt=2, done_id=0, aborted=0.
REQ-034 Defaults, req=11 from reset, both held -> grant order 01, 10, 01; gnt never 11.
REQ-035 Defaults, req[1] drops after 5 valid bits 10010 -> frame_done with aborted=1, match_cnt=1, done_id=1.
REQ-036 Defaults, bit_vld toggling every other cycle -> only qualified bits count; frame_done after exactly 16 valid bits.
REQ-037 Defaults, 1001 on the 16th bit -> match pulse and frame_done in the same cycle; match_cnt includes that match.
REQ-038 rst pulse mid-RUN -> all outputs 0 next cycle; no frame_done; next tie goes to requester 0.
